// File: rtl/fft_pkg.sv
// fft_pkg: shared saturation limits and complex-sample type for the radix-2 butterfly.
package fft_pkg;
  localparam int FFT_W = 16;
  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction
  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction
  localparam longint SAT_MAX = sat_max(FFT_W);
  localparam longint SAT_MIN = sat_min(FFT_W);
  typedef struct packed {
    logic signed [FFT_W-1:0] re;
    logic signed [FFT_W-1:0] im;
  } cplx_t;
endpackage

// File: rtl/q15_mul.sv
// q15_mul: signed Q1.(BIT_WIDTH-1) multiply with round-half-up, wrapping result.
module q15_mul #(
  parameter int BIT_WIDTH = 16
) (
  input  logic signed [BIT_WIDTH-1:0] a,
  input  logic signed [BIT_WIDTH-1:0] b,
  output logic signed [BIT_WIDTH-1:0] p
);
  logic signed [2*BIT_WIDTH-1:0] f;
  logic unused_sign;
  assign f = a * b;
  assign unused_sign = f[2*BIT_WIDTH-1];
  // -1 x -1 deliberately wraps; the sign bit of the full product is dropped
  assign p = f[2*BIT_WIDTH-2:BIT_WIDTH-1] + BIT_WIDTH'(f[BIT_WIDTH-2]);
endmodule

// File: rtl/sat_shift.sv
// sat_shift: halve a widened butterfly sum (floor) and saturate to the sample range.
module sat_shift import fft_pkg::*; #(
  parameter int BIT_WIDTH = 16
) (
  input  logic signed [BIT_WIDTH+1:0] s,
  output logic signed [BIT_WIDTH-1:0] y
);
  localparam logic signed [BIT_WIDTH:0] MAX = (BIT_WIDTH+1)'(sat_max(BIT_WIDTH));
  localparam logic signed [BIT_WIDTH:0] MIN = (BIT_WIDTH+1)'(sat_min(BIT_WIDTH));
  logic signed [BIT_WIDTH:0] h;
  assign h = (BIT_WIDTH+1)'(s >>> 1);
  assign y = h > MAX ? MAX[BIT_WIDTH-1:0] : h < MIN ? MIN[BIT_WIDTH-1:0] : h[BIT_WIDTH-1:0];
endmodule

// File: rtl/fft_butterfly.sv
// fft_butterfly: 3-stage pipelined radix-2 DIT butterfly, X=(A+WB)/2, Y=(A-WB)/2, with tag passthrough.
module fft_butterfly import fft_pkg::*; #(
  parameter int BIT_WIDTH = 16,
  parameter int IDX_W     = 9
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [BIT_WIDTH-1:0] a_re,
  input  logic signed [BIT_WIDTH-1:0] a_im,
  input  logic signed [BIT_WIDTH-1:0] b_re,
  input  logic signed [BIT_WIDTH-1:0] b_im,
  input  logic signed [BIT_WIDTH-1:0] w_re,
  input  logic signed [BIT_WIDTH-1:0] w_im,
  input  logic [IDX_W-1:0]            in_idx,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [BIT_WIDTH-1:0] x_re,
  output logic signed [BIT_WIDTH-1:0] x_im,
  output logic signed [BIT_WIDTH-1:0] y_re,
  output logic signed [BIT_WIDTH-1:0] y_im,
  output logic [IDX_W-1:0]            out_idx,
  output logic                        busy
);
  localparam int W = BIT_WIDTH;
  logic adv, v1, v2;
  logic signed [W-1:0] a1_re, a1_im, b1_re, b1_im, w1_re, w1_im;
  logic signed [W-1:0] a2_re, a2_im, m_rr, m_ii, m_ri, m_ir, m2_rr, m2_ii, m2_ri, m2_ir;
  logic [IDX_W-1:0] idx1, idx2;
  logic signed [W:0] p_re, p_im;
  logic signed [W+1:0] s_xr, s_xi, s_yr, s_yi;
  logic signed [W-1:0] xr_d, xi_d, yr_d, yi_d;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;
  assign busy     = v1 | v2 | out_valid;
  q15_mul #(.BIT_WIDTH(W)) u_rr (.a(b1_re), .b(w1_re), .p(m_rr));
  q15_mul #(.BIT_WIDTH(W)) u_ii (.a(b1_im), .b(w1_im), .p(m_ii));
  q15_mul #(.BIT_WIDTH(W)) u_ri (.a(b1_re), .b(w1_im), .p(m_ri));
  q15_mul #(.BIT_WIDTH(W)) u_ir (.a(b1_im), .b(w1_re), .p(m_ir));
  // one guard bit for the product sum, two for the butterfly sums: nothing can overflow before saturation
  assign p_re = {m2_rr[W-1], m2_rr} - {m2_ii[W-1], m2_ii};
  assign p_im = {m2_ri[W-1], m2_ri} + {m2_ir[W-1], m2_ir};
  assign s_xr = {{2{a2_re[W-1]}}, a2_re} + {p_re[W], p_re};
  assign s_xi = {{2{a2_im[W-1]}}, a2_im} + {p_im[W], p_im};
  assign s_yr = {{2{a2_re[W-1]}}, a2_re} - {p_re[W], p_re};
  assign s_yi = {{2{a2_im[W-1]}}, a2_im} - {p_im[W], p_im};
  sat_shift #(.BIT_WIDTH(W)) u_sxr (.s(s_xr), .y(xr_d));
  sat_shift #(.BIT_WIDTH(W)) u_sxi (.s(s_xi), .y(xi_d));
  sat_shift #(.BIT_WIDTH(W)) u_syr (.s(s_yr), .y(yr_d));
  sat_shift #(.BIT_WIDTH(W)) u_syi (.s(s_yi), .y(yi_d));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {v1, v2, out_valid} <= '0;
      {a1_re, a1_im, b1_re, b1_im, w1_re, w1_im, idx1} <= '0;
      {a2_re, a2_im, m2_rr, m2_ii, m2_ri, m2_ir, idx2} <= '0;
      {x_re, x_im, y_re, y_im, out_idx} <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      a1_re     <= a_re;
      a1_im     <= a_im;
      b1_re     <= b_re;
      b1_im     <= b_im;
      w1_re     <= w_re;
      w1_im     <= w_im;
      idx1      <= in_idx;
      v2        <= v1;
      a2_re     <= a1_re;
      a2_im     <= a1_im;
      m2_rr     <= m_rr;
      m2_ii     <= m_ii;
      m2_ri     <= m_ri;
      m2_ir     <= m_ir;
      idx2      <= idx1;
      out_valid <= v2;
      x_re      <= xr_d;
      x_im      <= xi_d;
      y_re      <= yr_d;
      y_im      <= yi_d;
      out_idx   <= idx2;
    end
  end
endmodule
